// File: rtl/combo_lock_fsm.sv
// Parametrised keypad combination lock: edge-detected one-hot presses, fail
// counter with timed alarm lockout, optional auto-relock and in-field reprogramming.
module combo_lock_fsm #(
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned CODE_LEN    = 3,
  parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0] RESET_CODE = 6'h27,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 8,
  parameter int unsigned UNLOCK_CYC  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_BTN-1:0]              btn,
  input  logic                            clear,
  input  logic                            prog,
  output logic                            lock,
  output logic                            alarm,
  output logic                            prog_busy,
  output logic [$clog2(CODE_LEN+1)-1:0]   progress,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fails
);

  localparam int unsigned IDX_W = $clog2(NUM_BTN);
  localparam int unsigned PW    = $clog2(CODE_LEN + 1);
  localparam int unsigned FW    = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam int unsigned RW    = (UNLOCK_CYC > 1) ? $clog2(UNLOCK_CYC) : 1;

  localparam logic [LW-1:0] LOCKOUT_LOAD = LW'(LOCKOUT_CYC - 1);
  localparam logic [RW-1:0] RELOCK_LOAD  = RW'((UNLOCK_CYC > 0) ? UNLOCK_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  typedef logic [CODE_LEN-1:0][IDX_W-1:0] code_t;

  state_t             state_q, state_d;
  code_t              code_q, code_d;
  code_t              shadow_q, shadow_d;
  logic [PW-1:0]      prog_q, prog_d;
  logic [FW-1:0]      fails_q, fails_d;
  logic [LW-1:0]      ltmr_q, ltmr_d;
  logic [RW-1:0]      rtmr_q, rtmr_d;
  logic [NUM_BTN-1:0] btn_q;
  logic               lock_q, lock_d;
  logic               alarm_q, alarm_d;
  logic               busy_q, busy_d;

  logic               press;
  logic               valid;
  logic               last_digit;
  logic [IDX_W-1:0]   digit;
  logic [IDX_W-1:0]   cur_digit;
  logic [FW-1:0]      fails_inc;

  assign press      = (btn != '0) && (btn_q == '0);
  assign valid      = $onehot(btn);
  assign last_digit = (prog_q == PW'(CODE_LEN - 1));
  assign fails_inc  = fails_q + FW'(1);

  always_comb begin
    digit = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (btn[i]) digit = IDX_W'(i);
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (prog_q == PW'(i)) cur_digit = code_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    prog_d   = prog_q;
    fails_d  = fails_q;
    ltmr_d   = ltmr_q;
    rtmr_d   = rtmr_q;

    case (state_q)
      ENTRY: begin
        if (clear) begin
          prog_d = '0;
        end else if (press) begin
          if (valid && (digit == cur_digit)) begin
            if (last_digit) begin
              state_d = UNLOCKED;
              fails_d = '0;
              prog_d  = '0;
              rtmr_d  = RELOCK_LOAD;
            end else begin
              prog_d = prog_q + PW'(1);
            end
          end else begin
            // A wrong digit only restarts entry; it is not reused as digit 0.
            prog_d  = '0;
            fails_d = fails_inc;
            if (fails_inc == FW'(MAX_FAIL)) begin
              state_d = LOCKOUT;
              ltmr_d  = LOCKOUT_LOAD;
            end
          end
        end
      end

      LOCKOUT: begin
        if (ltmr_q == '0) begin
          state_d = ENTRY;
          fails_d = '0;
          prog_d  = '0;
        end else begin
          ltmr_d = ltmr_q - LW'(1);
        end
      end

      UNLOCKED: begin
        if (clear) begin
          state_d = ENTRY;
        end else if (prog) begin
          state_d = PROGRAM;
          prog_d  = '0;
        end else if (UNLOCK_CYC > 0) begin
          if (rtmr_q == '0) state_d = ENTRY;
          else              rtmr_d  = rtmr_q - RW'(1);
        end
      end

      PROGRAM: begin
        if (clear) begin
          state_d = ENTRY;
          prog_d  = '0;
        end else if (press) begin
          if (valid) begin
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
              if (prog_q == PW'(i)) shadow_d[i] = digit;
            end
            if (last_digit) begin
              // Commit includes the digit captured on this same edge.
              code_d  = shadow_d;
              state_d = UNLOCKED;
              prog_d  = '0;
              rtmr_d  = RELOCK_LOAD;
            end else begin
              prog_d = prog_q + PW'(1);
            end
          end else begin
            state_d = UNLOCKED;
            prog_d  = '0;
          end
        end
      end

      default: begin
        state_d = ENTRY;
        prog_d  = '0;
      end
    endcase

    lock_d  = !((state_d == UNLOCKED) || (state_d == PROGRAM));
    alarm_d = (state_d == LOCKOUT);
    busy_d  = (state_d == PROGRAM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENTRY;
      code_q   <= RESET_CODE;
      shadow_q <= '0;
      prog_q   <= '0;
      fails_q  <= '0;
      ltmr_q   <= '0;
      rtmr_q   <= '0;
      btn_q    <= '1;
      lock_q   <= 1'b1;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      prog_q   <= prog_d;
      fails_q  <= fails_d;
      ltmr_q   <= ltmr_d;
      rtmr_q   <= rtmr_d;
      btn_q    <= btn;
      lock_q   <= lock_d;
      alarm_q  <= alarm_d;
      busy_q   <= busy_d;
    end
  end

  assign lock      = lock_q;
  assign alarm     = alarm_q;
  assign prog_busy = busy_q;
  assign progress  = prog_q;
  assign fails     = fails_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Scoreboard bench for combo_lock_fsm: one instance with default timing, one
// with a 5-cycle auto-relock.
module tb_combo_lock_fsm;

  logic       clk = 1'b0;
  logic       rst, clear, prog;
  logic [3:0] btn;

  logic       lock_a, alarm_a, busy_a;
  logic [1:0] progress_a, fails_a;
  logic       lock_b, alarm_b, busy_b;
  logic [1:0] progress_b, fails_b;

  int compared   = 0;
  int mismatched = 0;
  bit sel_b      = 1'b0;

  typedef struct {
    logic [6:0] v;
    string      nm;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] act_q[$];

  always #5 clk = ~clk;

  combo_lock_fsm #(
    .NUM_BTN(4), .CODE_LEN(3), .RESET_CODE(6'h27),
    .MAX_FAIL(3), .LOCKOUT_CYC(8), .UNLOCK_CYC(0)
  ) dut_a (
    .clk(clk), .rst(rst), .btn(btn), .clear(clear), .prog(prog),
    .lock(lock_a), .alarm(alarm_a), .prog_busy(busy_a),
    .progress(progress_a), .fails(fails_a)
  );

  combo_lock_fsm #(
    .NUM_BTN(4), .CODE_LEN(3), .RESET_CODE(6'h27),
    .MAX_FAIL(3), .LOCKOUT_CYC(8), .UNLOCK_CYC(5)
  ) dut_b (
    .clk(clk), .rst(rst), .btn(btn), .clear(clear), .prog(prog),
    .lock(lock_b), .alarm(alarm_b), .prog_busy(busy_b),
    .progress(progress_b), .fails(fails_b)
  );

  // {lock, alarm, prog_busy, progress[1:0], fails[1:0]}
  function automatic logic [6:0] st(input logic l, input logic a, input logic pb,
                                    input int pr, input int f);
    return {l, a, pb, 2'(pr), 2'(f)};
  endfunction

  task automatic drive(input logic r, input logic [3:0] b, input logic c,
                       input logic p, input logic [6:0] e, input string nm);
    @(negedge clk);
    rst = r; btn = b; clear = c; prog = p;
    exp_q.push_back('{v: e, nm: nm});
    @(posedge clk);
    #1;
    if (sel_b) act_q.push_back({lock_b, alarm_b, busy_b, progress_b, fails_b});
    else       act_q.push_back({lock_a, alarm_a, busy_a, progress_a, fails_a});
  endtask

  task automatic press_seq(input logic [3:0] b, input logic [6:0] e, input string nm);
    drive(1'b0, b, 1'b0, 1'b0, e, nm);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, e, {nm, "_gap"});
  endtask

  task automatic test_reset();
    exp_t e; logic [6:0] o;
    sel_b = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "reset_a");
    sel_b = 1'b1;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "reset_b");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "reset_idle_b");
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
      if (o !== e.v) begin
        mismatched++;
        $display("FAIL %s: lock/alarm/busy/progress/fails got %b want %b", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_unlock();
    exp_t e; logic [6:0] o;
    sel_b = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "u_rst");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "u_idle");
    press_seq(4'b1000, st(1,0,0,1,0), "u_d0");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,1,0), "u_idle2");
    press_seq(4'b0010, st(1,0,0,2,0), "u_d1");
    drive(1'b0, 4'b0100, 1'b0, 1'b0, st(0,0,0,0,0), "u_d2_unlock");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(0,0,0,0,0), "u_stay");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(0,0,0,0,0), "u_stay2");
    press_seq(4'b1000, st(0,0,0,0,0), "u_press_ignored");
    drive(1'b0, 4'b0000, 1'b1, 1'b0, st(1,0,0,0,0), "u_clear_relock");
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
      if (o !== e.v) begin
        mismatched++;
        $display("FAIL %s: lock/alarm/busy/progress/fails got %b want %b", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_lockout();
    exp_t e; logic [6:0] o;
    logic [3:0] pat [7];
    pat = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    sel_b = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "l_rst");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "l_idle");
    press_seq(4'b1000, st(1,0,0,1,0), "l_d0");
    press_seq(4'b0001, st(1,0,0,0,1), "l_wrong1");
    press_seq(4'b0001, st(1,0,0,0,2), "l_wrong2");
    drive(1'b0, 4'b0001, 1'b0, 1'b0, st(1,1,0,0,3), "l_lockout_enter");
    for (int i = 0; i < 7; i++)
      drive(1'b0, pat[i], (i == 6), (i == 5), st(1,1,0,0,3), "l_alarm_hold");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "l_alarm_end");
    drive(1'b0, 4'b1000, 1'b0, 1'b0, st(1,0,0,1,0), "l_entry_after");
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
      if (o !== e.v) begin
        mismatched++;
        $display("FAIL %s: lock/alarm/busy/progress/fails got %b want %b", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_held();
    exp_t e; logic [6:0] o;
    sel_b = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "h_rst");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "h_idle");
    for (int i = 0; i < 5; i++)
      drive(1'b0, 4'b1000, 1'b0, 1'b0, st(1,0,0,1,0), "h_held");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,1,0), "h_release");
    press_seq(4'b1010, st(1,0,0,0,1), "h_multihot");
    drive(1'b1, 4'b1000, 1'b0, 1'b0, st(1,0,0,0,0), "h_rst_held");
    drive(1'b0, 4'b1000, 1'b0, 1'b0, st(1,0,0,0,0), "h_held_after_rst");
    drive(1'b0, 4'b1000, 1'b0, 1'b0, st(1,0,0,0,0), "h_held_after_rst2");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "h_release2");
    drive(1'b0, 4'b1000, 1'b0, 1'b0, st(1,0,0,1,0), "h_press_after_release");
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
      if (o !== e.v) begin
        mismatched++;
        $display("FAIL %s: lock/alarm/busy/progress/fails got %b want %b", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_program();
    exp_t e; logic [6:0] o;
    sel_b = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "p_rst");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "p_idle");
    press_seq(4'b1000, st(1,0,0,1,0), "p_d0");
    press_seq(4'b0010, st(1,0,0,2,0), "p_d1");
    press_seq(4'b0100, st(0,0,0,0,0), "p_unlock");
    drive(1'b0, 4'b0000, 1'b0, 1'b1, st(0,0,1,0,0), "p_prog_enter");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(0,0,1,0,0), "p_prog_idle");
    press_seq(4'b0001, st(0,0,1,1,0), "p_cap0");
    press_seq(4'b0001, st(0,0,1,2,0), "p_cap1");
    press_seq(4'b0010, st(0,0,0,0,0), "p_prog_done");
    drive(1'b0, 4'b0000, 1'b1, 1'b0, st(1,0,0,0,0), "p_clear");
    press_seq(4'b1000, st(1,0,0,0,1), "p_old_code_fails");
    press_seq(4'b0001, st(1,0,0,1,1), "p_new0");
    press_seq(4'b0001, st(1,0,0,2,1), "p_new1");
    press_seq(4'b0010, st(0,0,0,0,0), "p_new_code_unlocks");
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
      if (o !== e.v) begin
        mismatched++;
        $display("FAIL %s: lock/alarm/busy/progress/fails got %b want %b", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_relock();
    exp_t e; logic [6:0] o;
    sel_b = 1'b1;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "r_rst");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "r_idle");
    press_seq(4'b1000, st(1,0,0,1,0), "r_d0");
    press_seq(4'b0010, st(1,0,0,2,0), "r_d1");
    drive(1'b0, 4'b0100, 1'b0, 1'b0, st(0,0,0,0,0), "r_unlock");
    for (int i = 0; i < 4; i++)
      drive(1'b0, 4'b0000, 1'b0, 1'b0, st(0,0,0,0,0), "r_wait");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "r_relock");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "r_stays_locked");
    press_seq(4'b1000, st(1,0,0,1,0), "r2_d0");
    press_seq(4'b0010, st(1,0,0,2,0), "r2_d1");
    drive(1'b0, 4'b0100, 1'b0, 1'b0, st(0,0,0,0,0), "r2_unlock");
    drive(1'b0, 4'b0000, 1'b0, 1'b1, st(0,0,1,0,0), "r2_prog");
    press_seq(4'b0001, st(0,0,1,1,0), "r2_cap0");
    drive(1'b0, 4'b0000, 1'b1, 1'b0, st(1,0,0,0,0), "r2_prog_abort");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "r2_idle");
    press_seq(4'b1000, st(1,0,0,1,0), "r3_d0");
    press_seq(4'b0010, st(1,0,0,2,0), "r3_d1");
    drive(1'b0, 4'b0100, 1'b0, 1'b0, st(0,0,0,0,0), "r3_code_kept");
    drive(1'b0, 4'b0000, 1'b0, 1'b1, st(0,0,1,0,0), "r3_prog");
    for (int i = 0; i < 6; i++)
      drive(1'b0, 4'b0000, 1'b0, 1'b0, st(0,0,1,0,0), "r3_frozen");
    drive(1'b0, 4'b1010, 1'b0, 1'b0, st(0,0,0,0,0), "r3_invalid_abort");
    for (int i = 0; i < 4; i++)
      drive(1'b0, 4'b0000, 1'b0, 1'b0, st(0,0,0,0,0), "r3_wait");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "r3_relock");
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
      if (o !== e.v) begin
        mismatched++;
        $display("FAIL %s: lock/alarm/busy/progress/fails got %b want %b", e.nm, o, e.v);
      end
    end
  endtask

  task automatic test_clear_same_edge();
    exp_t e; logic [6:0] o;
    sel_b = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "c_rst");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "c_idle");
    press_seq(4'b1000, st(1,0,0,1,0), "c_d0");
    press_seq(4'b0010, st(1,0,0,2,0), "c_d1");
    drive(1'b0, 4'b0100, 1'b1, 1'b0, st(1,0,0,0,0), "c_clear_beats_digit");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, st(1,0,0,0,0), "c_still_locked");
    press_seq(4'b0001, st(1,0,0,0,1), "c_wrong");
    drive(1'b0, 4'b0000, 1'b1, 1'b0, st(1,0,0,0,1), "c_clear_keeps_fails");
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
      if (o !== e.v) begin
        mismatched++;
        $display("FAIL %s: lock/alarm/busy/progress/fails got %b want %b", e.nm, o, e.v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; btn = 4'b0000; clear = 1'b0; prog = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_held();
    test_program();
    test_relock();
    test_clear_same_edge();
    if (exp_q.size() != 0 || act_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: left exp=%0d act=%0d want 0/0", exp_q.size(), act_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
